seq_det_scan_ctrl: RTL and testbench

//  Controller that shares one bit-serial 1001 detector (non-overlap Mealy, registered output) among
//  N_REQ requesters. It arbitrates round-robin, captures the winner's WORD_W-bit word and clears the

---
 rtl/seq_det_scan_ctrl_if.sv | 28 ++
 rtl/seq_det_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_det_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_scan_ctrl_if.sv
// Requester / response bus for seq_det_scan_ctrl.
// master: word producers and response consumer. slave: the scan controller.
interface seq_det_scan_ctrl_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 16
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [CNT_W-1:0]        rsp_count;
    logic                    rsp_found;

    modport master (
        output req, req_data, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_count, rsp_found
    );

    modport slave (
        input  req, req_data, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_count, rsp_found
    );
endinterface

// File: rtl/seq_det_scan_ctrl.sv
// Shares one bit-serial "1001" detector (non-overlap Mealy, registered output)
// among N_REQ requesters. Round-robin grant, capture word, clear detector,
// shift word MSB-first, count hits, return one response per word.
// Optional statistics counters are built only when SEQ_CTRL_STATS_EN is defined.
module seq_det_scan_ctrl #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    seq_det_scan_ctrl_if.slave  bus,
    output logic                det_rst_n,
    output logic                det_bit,
    input  logic                det_hit,
    output logic [15:0]         stat_words,
    output logic [15:0]         stat_hits
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  hit_next;
    logic [ID_W-1:0]   rr_ptr;
    logic              win_valid;
    logic [ID_W-1:0]   win_idx;
    logic              accept;

    // The shift register drains to zero, so its MSB is also 0 in DRAIN/DONE/IDLE.
    assign det_bit  = shreg[WORD_W-1];
    assign hit_next = hit_cnt + CNT_W'(det_hit);
    assign accept   = (state == DONE) && bus.rsp_ready;

    // Round-robin pick: first requester at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        // NOTE: every output gets a default first so no path infers a latch.
        win_valid = 1'b0;
        win_idx   = '0;
        j         = 0;
        // Walk from farthest to nearest so the nearest set request wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (bus.req[j]) begin
                win_valid = 1'b1;
                win_idx   = ID_W'(j);
            end
        end
    end

    // Main scan FSM; all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            shreg         <= '0;
            bit_cnt       <= '0;
            hit_cnt       <= '0;
            det_rst_n     <= 1'b0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_count <= '0;
            bus.rsp_found <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere so each register sees pre-edge values.
            bus.gnt <= '0;
            case (state)
                IDLE: begin
                    det_rst_n <= 1'b0;
                    if (win_valid) begin
                        shreg      <= bus.req_data[int'(win_idx)*WORD_W +: WORD_W];
                        bus.rsp_id <= win_idx;
                        bus.gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        state      <= CLR;
                    end
                end
                CLR: begin
                    // Detector stays in reset through this cycle, released for SHIFT.
                    det_rst_n <= 1'b1;
                    bit_cnt   <= CNT_W'(WORD_W);
                    hit_cnt   <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    // First SHIFT cycle sees the detector's post-reset output, not a bit result.
                    if (bit_cnt != CNT_W'(WORD_W)) hit_cnt <= hit_next;
                    if (bit_cnt == CNT_W'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    // det_hit here is the result for the last shifted bit.
                    bus.rsp_count <= hit_next;
                    bus.rsp_found <= (hit_next != '0);
                    bus.rsp_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        det_rst_n     <= 1'b0;
                        rr_ptr        <= (bus.rsp_id == ID_W'(N_REQ - 1)) ? '0 : bus.rsp_id + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_CTRL_STATS_EN
    logic [16:0] hits_sum;
    assign hits_sum = {1'b0, stat_hits} + 17'(bus.rsp_count);

    // Saturating word/hit totals, updated on each accepted response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words <= '0;
            stat_hits  <= '0;
        end else if (accept) begin
            if (stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
            stat_hits <= hits_sum[16] ? 16'hFFFF : hits_sum[15:0];
        end
    end
`else
    assign stat_words = '0;
    assign stat_hits  = '0;
`endif

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Directed bench for seq_det_scan_ctrl with a behavioural 1001 detector.
module tb_seq_det_scan_ctrl;
    localparam int N_REQ  = 4;
    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        det_rst_n;
    logic        det_bit;
    logic        det_hit;
    logic [15:0] stat_words;
    logic [15:0] stat_hits;
    logic [1:0]  ref_st;

    int n_checks = 0;
    int n_pass   = 0;

    seq_det_scan_ctrl_if #(.N_REQ(N_REQ), .WORD_W(WORD_W)) bus ();

    seq_det_scan_ctrl #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .det_rst_n  (det_rst_n),
        .det_bit    (det_bit),
        .det_hit    (det_hit),
        .stat_words (stat_words),
        .stat_hits  (stat_hits)
    );

    always #5 clk = ~clk;

    // External 1001 detector: non-overlapping, output registered one cycle after the final 1.
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            ref_st  <= 2'd0;
            det_hit <= 1'b0;
        end else begin
            det_hit <= (ref_st == 2'd3) && det_bit;
            case (ref_st)
                2'd0:    ref_st <= det_bit ? 2'd1 : 2'd0;
                2'd1:    ref_st <= det_bit ? 2'd1 : 2'd2;
                2'd2:    ref_st <= det_bit ? 2'd1 : 2'd3;
                default: ref_st <= 2'd0;
            endcase
        end
    end

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Step negedges until a grant appears or the budget runs out.
    task automatic wait_gnt(input int budget, output int waited, output logic [N_REQ-1:0] g);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.gnt == '0 && waited < budget);
        g = bus.gnt;
    endtask

    // Let any scan in flight finish and be accepted, with no new requests.
    task automatic drain_idle();
        bus.req       = '0;
        bus.rsp_ready = 1'b1;
        repeat (25) @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 1'b0) $display("FAIL reset_gnt_valid: got gnt=%b valid=%b, want 0000/0", bus.gnt, bus.rsp_valid);
        else n_pass++;
        n_checks++;
        if (det_rst_n !== 1'b0 || det_bit !== 1'b0) $display("FAIL reset_det: got det_rst_n=%b det_bit=%b, want 0/0", det_rst_n, det_bit);
        else n_pass++;
        n_checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_count !== 5'd0 || bus.rsp_found !== 1'b0)
            $display("FAIL reset_rsp: got id=%0d count=%0d found=%b, want 0/0/0", bus.rsp_id, bus.rsp_count, bus.rsp_found);
        else n_pass++;
        n_checks++;
        if (stat_words !== 16'd0 || stat_hits !== 16'd0) $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_words, stat_hits);
        else n_pass++;
    endtask

    // One requester, one word: grant, latency, detector reset framing, result, acceptance.
    task automatic test_scan(input int idx, input logic [15:0] word, input int exp_count);
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] exp_g;
        int w;
        int lat;
        exp_g      = '0;
        exp_g[idx] = 1'b1;
        bus.req      = '0;
        bus.req[idx] = 1'b1;
        bus.req_data[idx*WORD_W +: WORD_W] = word;
        bus.rsp_ready = 1'b0;
        wait_gnt(30, w, g);
        n_checks++;
        if (g !== exp_g) $display("FAIL scan_gnt %h: got %b, want %b", word, g, exp_g);
        else n_pass++;
        n_checks++;
        if (det_rst_n !== 1'b0) $display("FAIL scan_clr_det_rst %h: got %b, want 0", word, det_rst_n);
        else n_pass++;
        bus.req = '0;
        @(negedge clk);
        lat = 1;
        n_checks++;
        if (det_rst_n !== 1'b1) $display("FAIL scan_shift_det_rst %h: got %b, want 1", word, det_rst_n);
        else n_pass++;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 18) $display("FAIL scan_latency %h: got %0d cycles, want 18", word, lat);
        else n_pass++;
        n_checks++;
        if (bus.rsp_id !== 2'(idx) || bus.rsp_count !== CNT_W'(exp_count) || bus.rsp_found !== (exp_count != 0))
            $display("FAIL scan_rsp %h: got id=%0d count=%0d found=%b, want id=%0d count=%0d found=%b",
                     word, bus.rsp_id, bus.rsp_count, bus.rsp_found, idx, exp_count, exp_count != 0);
        else n_pass++;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL scan_accept %h: rsp_valid got %b, want 0", word, bus.rsp_valid);
        else n_pass++;
    endtask

    // All four requesting, ready tied high: grants 0,1,2,3,0 at one per 20 cycles.
    task automatic test_back_to_back();
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] exp_g;
        int w;
        do_reset();
        bus.req_data  = {16'h0000, 16'h9200, 16'h9999, 16'h9000};
        bus.req       = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(30, w, g);
            exp_g = 4'b0001 << (n % 4);
            n_checks++;
            if (g !== exp_g) $display("FAIL rr_order[%0d]: got %b, want %b", n, g, exp_g);
            else n_pass++;
            if (n > 0) begin
                n_checks++;
                if (w !== 20) $display("FAIL rr_spacing[%0d]: got %0d cycles, want 20", n, w);
                else n_pass++;
            end
        end
        drain_idle();
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL rr_drain: rsp_valid got %b, want 0", bus.rsp_valid);
        else n_pass++;
    endtask

    // Response held for 10 cycles: stable outputs, no grant, then accepted and next requester served.
    task automatic test_backpressure();
        logic [N_REQ-1:0] g;
        logic [1:0]       id0;
        logic [4:0]       cnt0;
        logic             fnd0;
        int w;
        int lat;
        bit stable;
        // Pointer is 1 after the previous test served requester 0 last.
        bus.req       = 4'b1111;
        bus.rsp_ready = 1'b0;
        wait_gnt(30, w, g);
        n_checks++;
        if (g !== 4'b0010) $display("FAIL bp_gnt: got %b, want 0010", g);
        else n_pass++;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_count !== 5'd4) $display("FAIL bp_rsp: got valid=%b count=%0d, want 1/4", bus.rsp_valid, bus.rsp_count);
        else n_pass++;
        id0    = bus.rsp_id;
        cnt0   = bus.rsp_count;
        fnd0   = bus.rsp_found;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== id0 || bus.rsp_count !== cnt0 ||
                bus.rsp_found !== fnd0 || bus.gnt !== 4'b0000) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL bp_hold: got changing rsp or a grant, want stable rsp and no grant");
        else n_pass++;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL bp_accept: rsp_valid got %b, want 0", bus.rsp_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b0100) $display("FAIL bp_next_gnt: got %b, want 0100", bus.gnt);
        else n_pass++;
        drain_idle();
    endtask

    // Reset during SHIFT: detector held, no response, pointer back to 0.
    task automatic test_reset_mid_shift();
        logic [N_REQ-1:0] g;
        int w;
        bit quiet;
        do_reset();
        test_scan(2, 16'h9000, 1);
        bus.req_data[3*WORD_W +: WORD_W] = 16'h9999;
        bus.req = 4'b1000;
        wait_gnt(30, w, g);
        n_checks++;
        if (g !== 4'b1000) $display("FAIL mid_gnt: got %b, want 1000", g);
        else n_pass++;
        bus.req = '0;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (det_rst_n !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0000)
            $display("FAIL mid_reset_out: got det_rst_n=%b valid=%b gnt=%b, want 0/0/0000", det_rst_n, bus.rsp_valid, bus.gnt);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || det_rst_n !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL mid_discard: got a response or detector release after reset, want none");
        else n_pass++;
        bus.req = 4'b1111;
        wait_gnt(30, w, g);
        n_checks++;
        if (g !== 4'b0001) $display("FAIL mid_rr_ptr: got %b, want 0001", g);
        else n_pass++;
        drain_idle();
    endtask

    task automatic test_stats();
        do_reset();
        test_scan(0, 16'h9999, 4);
        test_scan(1, 16'h9000, 1);
`ifdef SEQ_CTRL_STATS_EN
        n_checks++;
        if (stat_words !== 16'd2 || stat_hits !== 16'd5) $display("FAIL stats: got %0d/%0d, want 2/5", stat_words, stat_hits);
        else n_pass++;
`else
        n_checks++;
        if (stat_words !== 16'd0 || stat_hits !== 16'd0) $display("FAIL stats: got %0d/%0d, want 0/0", stat_words, stat_hits);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_scan(0, 16'h9000, 1);
        test_scan(1, 16'h9999, 4);
        test_scan(2, 16'h9200, 1);
        test_scan(3, 16'h0000, 0);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
